// File: rtl/sha_pkg.sv
// Shared types and width helpers for the SHA-256 message-block read path.
package sha_pkg;

    localparam int unsigned DEFAULT_WORDS_PER_BLOCK = 16;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_READ     = 2'd1,
        ST_WAIT_ACK = 2'd2,
        ST_FINISH   = 2'd3
    } seq_state_e;

    // Index width that never collapses to zero bits.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned word_idx_width(input int unsigned words_per_block);
        return idx_width(words_per_block);
    endfunction

    function automatic int unsigned block_idx_width(input int unsigned max_blocks);
        return idx_width(max_blocks);
    endfunction

    function automatic int unsigned count_width(input int unsigned max_blocks);
        return $clog2(max_blocks + 1);
    endfunction

endpackage

// File: rtl/sha_block_sequencer_if.sv
// Control, memory-read and word-delivery signals of the block sequencer.
interface sha_block_sequencer_if
    import sha_pkg::*;
#(
    parameter int unsigned WORDS_PER_BLOCK = DEFAULT_WORDS_PER_BLOCK,
    parameter int unsigned MAX_BLOCKS      = 8,
    parameter int unsigned ADDR_WIDTH      = $clog2(WORDS_PER_BLOCK * MAX_BLOCKS)
) ();

    localparam int unsigned BW     = count_width(MAX_BLOCKS);
    localparam int unsigned WIDX_W = word_idx_width(WORDS_PER_BLOCK);
    localparam int unsigned BIDX_W = block_idx_width(MAX_BLOCKS);

    logic                  start;
    logic                  abort;
    logic [BW-1:0]         num_blocks;
    logic [ADDR_WIDTH-1:0] base_address;
    logic                  block_ack;
    logic                  mem_read_en;
    logic [ADDR_WIDTH-1:0] mem_read_address;
    logic                  word_valid;
    logic [WIDX_W-1:0]     word_index;
    logic [BIDX_W-1:0]     block_index;
    logic                  first_word;
    logic                  last_word;
    logic                  last_block;
    logic                  busy;
    logic                  done;

    modport master (
        input  start, abort, num_blocks, base_address, block_ack,
        output mem_read_en, mem_read_address, word_valid, word_index, block_index,
               first_word, last_word, last_block, busy, done
    );

    modport slave (
        output start, abort, num_blocks, base_address, block_ack,
        input  mem_read_en, mem_read_address, word_valid, word_index, block_index,
               first_word, last_word, last_block, busy, done
    );

endinterface

// File: rtl/sha_latency_pipe.sv
// Valid/tag delay line matching RAM read latency; DEPTH of zero is a bypass.
module sha_latency_pipe #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned TAG_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    output logic [TAG_W-1:0] out_tag,
    output logic             empty
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic unused_c;
            assign unused_c  = ^{clock, reset, clear};
            assign out_valid = in_valid;
            assign out_tag   = in_tag;
            assign empty     = 1'b1;
        end else begin : g_shift
            logic [DEPTH-1:0]            valid_q, valid_d;
            logic [DEPTH-1:0][TAG_W-1:0] tag_q, tag_d;

            always_comb begin
                valid_d    = valid_q;
                tag_d      = tag_q;
                valid_d[0] = in_valid;
                tag_d[0]   = in_tag;
                for (int i = 1; i < int'(DEPTH); i++) begin
                    valid_d[i] = valid_q[i-1];
                    tag_d[i]   = tag_q[i-1];
                end
                if (clear) begin
                    valid_d = '0;
                    tag_d   = '0;
                end
            end

            always_ff @(posedge clock) begin
                if (reset) begin
                    valid_q <= '0;
                    tag_q   <= '0;
                end else begin
                    valid_q <= valid_d;
                    tag_q   <= tag_d;
                end
            end

            assign out_valid = valid_q[DEPTH-1];
            assign out_tag   = tag_q[DEPTH-1];
            assign empty     = ~|valid_q;
        end
    endgenerate

endmodule

// File: rtl/sha_block_sequencer.sv
// Walks the message blocks in buffer RAM, one word read per cycle, and tags
// returning words for the compression core; waits for block_ack between blocks.
module sha_block_sequencer
    import sha_pkg::*;
#(
    parameter int unsigned WORDS_PER_BLOCK = DEFAULT_WORDS_PER_BLOCK,
    parameter int unsigned MAX_BLOCKS      = 8,
    parameter int unsigned ADDR_WIDTH      = $clog2(WORDS_PER_BLOCK * MAX_BLOCKS),
    parameter int unsigned MEM_LATENCY     = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    sha_block_sequencer_if.master bus
);

    localparam int unsigned BW     = count_width(MAX_BLOCKS);
    localparam int unsigned WIDX_W = word_idx_width(WORDS_PER_BLOCK);
    localparam int unsigned BIDX_W = block_idx_width(MAX_BLOCKS);
    localparam int unsigned TAG_W  = WIDX_W + BIDX_W + 3;

    seq_state_e            state_q, state_d;
    logic [WIDX_W-1:0]     word_q, word_d;
    logic [BIDX_W-1:0]     block_q, block_d;
    logic [BW-1:0]         nblk_q, nblk_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;

    logic                  rd_en_c;
    logic                  final_block_c;
    logic                  last_word_c;
    logic                  pipe_empty_c;
    logic [ADDR_WIDTH-1:0] rd_addr_c;
    logic [TAG_W-1:0]      tag_in_c;
    logic [TAG_W-1:0]      tag_out_c;
    logic                  valid_out_c;

    assign rd_en_c       = (state_q == ST_READ);
    assign final_block_c = (BW'(block_q) == nblk_q - BW'(1));
    assign last_word_c   = (word_q == WIDX_W'(WORDS_PER_BLOCK - 1));
    // Block stride is a power of two, so block/word concatenate into the offset.
    assign rd_addr_c     = base_q + ADDR_WIDTH'({block_q, word_q});
    assign tag_in_c      = rd_en_c ? {word_q, block_q, (word_q == '0), last_word_c, final_block_c}
                                   : '0;

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        block_d = block_q;
        nblk_d  = nblk_q;
        base_d  = base_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    nblk_d  = (bus.num_blocks > BW'(MAX_BLOCKS)) ? BW'(MAX_BLOCKS) : bus.num_blocks;
                    base_d  = bus.base_address;
                    word_d  = '0;
                    block_d = '0;
                    state_d = (bus.num_blocks == '0) ? ST_FINISH : ST_READ;
                end
            end
            ST_READ: begin
                word_d = word_q + WIDX_W'(1);
                if (last_word_c) begin
                    state_d = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                // An ack before the last word has left the pipe is dropped.
                if (bus.block_ack && pipe_empty_c) begin
                    if (final_block_c) begin
                        state_d = ST_FINISH;
                    end else begin
                        block_d = block_q + BIDX_W'(1);
                        word_d  = '0;
                        state_d = ST_READ;
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (bus.abort) begin
            state_d = ST_IDLE;
            word_d  = '0;
            block_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            word_q  <= '0;
            block_q <= '0;
            nblk_q  <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            block_q <= block_d;
            nblk_q  <= nblk_d;
            base_q  <= base_d;
        end
    end

    sha_latency_pipe #(
        .DEPTH (MEM_LATENCY),
        .TAG_W (TAG_W)
    ) u_pipe (
        .clock     (clock),
        .reset     (reset),
        .clear     (bus.abort),
        .in_valid  (rd_en_c),
        .in_tag    (tag_in_c),
        .out_valid (valid_out_c),
        .out_tag   (tag_out_c),
        .empty     (pipe_empty_c)
    );

    assign bus.mem_read_en      = rd_en_c;
    assign bus.mem_read_address = rd_en_c ? rd_addr_c : '0;
    assign bus.word_valid       = valid_out_c;
    assign {bus.word_index, bus.block_index, bus.first_word, bus.last_word, bus.last_block} = tag_out_c;
    assign bus.busy             = (state_q != ST_IDLE);
    assign bus.done             = (state_q == ST_FINISH);

endmodule

// File: tb/tb_sha_block_sequencer.sv
// Bench: two sequencers (read latency 1 and 3) on shared stimulus, checked
// every cycle against a queue/array model plus scenario tables and sequences.
module tb_sha_block_sequencer;

    typedef struct packed {
        logic       v;
        logic [3:0] w;
        logic [2:0] b;
        logic       f;
        logic       l;
        logic       lb;
        logic [6:0] a;
    } rec_t;

    typedef struct packed {
        logic       rd;
        logic [6:0] a;
        logic       v;
        logic [3:0] w;
        logic [2:0] b;
        logic       f;
        logic       l;
        logic       lb;
        logic       busy;
        logic       done;
    } obs_t;

    typedef struct {
        int nb;
        int base;
        int exp_reads;
        int exp_first;
        int exp_last;
        int exp_lb;
        int exp_done;
    } scn_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start_i = 1'b0;
    logic       abort_i = 1'b0;
    logic       ack_i = 1'b0;
    logic [3:0] nb_i = '0;
    logic [6:0] base_i = '0;

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;

    always #5 clock = ~clock;

    sha_block_sequencer_if #(.WORDS_PER_BLOCK(16), .MAX_BLOCKS(8), .ADDR_WIDTH(7)) if0 ();
    sha_block_sequencer_if #(.WORDS_PER_BLOCK(16), .MAX_BLOCKS(8), .ADDR_WIDTH(7)) if1 ();

    assign if0.start = start_i;  assign if1.start = start_i;
    assign if0.abort = abort_i;  assign if1.abort = abort_i;
    assign if0.block_ack = ack_i; assign if1.block_ack = ack_i;
    assign if0.num_blocks = nb_i; assign if1.num_blocks = nb_i;
    assign if0.base_address = base_i; assign if1.base_address = base_i;

    sha_block_sequencer #(.WORDS_PER_BLOCK(16), .MAX_BLOCKS(8), .ADDR_WIDTH(7), .MEM_LATENCY(1)) dut0 (
        .clock (clock), .reset (reset), .bus (if0.master));
    sha_block_sequencer #(.WORDS_PER_BLOCK(16), .MAX_BLOCKS(8), .ADDR_WIDTH(7), .MEM_LATENCY(3)) dut1 (
        .clock (clock), .reset (reset), .bus (if1.master));

    obs_t act [2];
    assign act[0] = {if0.mem_read_en, if0.mem_read_address, if0.word_valid, if0.word_index,
                     if0.block_index, if0.first_word, if0.last_word, if0.last_block, if0.busy, if0.done};
    assign act[1] = {if1.mem_read_en, if1.mem_read_address, if1.word_valid, if1.word_index,
                     if1.block_index, if1.first_word, if1.last_word, if1.last_block, if1.busy, if1.done};

    // ---------------- reference model ----------------
    rec_t       rd_buf [2][16];
    int         rd_head [2];
    int         rd_cnt [2];
    rec_t       dl [2][4];
    bit         active [2];
    bit         fin [2];
    int         nblk [2];
    int         blk [2];
    logic [6:0] mbase [2];

    function automatic int lat(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    task automatic load_block(input int k);
        rec_t r;
        for (int w = 0; w < 16; w++) begin
            r.v  = 1'b1;
            r.w  = 4'(w);
            r.b  = 3'(blk[k]);
            r.f  = (w == 0);
            r.l  = (w == 15);
            r.lb = (blk[k] == nblk[k] - 1);
            r.a  = 7'(int'(mbase[k]) + blk[k] * 16 + w);
            rd_buf[k][w] = r;
        end
        rd_head[k] = 0;
        rd_cnt[k]  = 16;
    endtask

    function automatic obs_t exp_obs(input int k);
        obs_t o;
        rec_t t;
        o.rd = (rd_cnt[k] > 0);
        o.a  = o.rd ? rd_buf[k][rd_head[k]].a : 7'd0;
        t    = dl[k][0];
        o.v  = t.v;
        o.w  = t.w;
        o.b  = t.b;
        o.f  = t.f;
        o.l  = t.l;
        o.lb = t.lb;
        o.busy = active[k] | fin[k];
        o.done = fin[k];
        return o;
    endfunction

    always @(posedge clock) begin
        for (int k = 0; k < 2; k++) begin
            bit   was_read;
            bit   empty;
            rec_t cur;
            was_read = (rd_cnt[k] > 0);
            cur      = was_read ? rd_buf[k][rd_head[k]] : '0;
            empty    = 1'b1;
            for (int i = 0; i < lat(k); i++) if (dl[k][i].v) empty = 1'b0;
            if (reset || abort_i) begin
                active[k] = 1'b0;
                fin[k]    = 1'b0;
                rd_cnt[k] = 0;
                for (int i = 0; i < 4; i++) dl[k][i] = '0;
            end else begin
                for (int i = 0; i < lat(k) - 1; i++) dl[k][i] = dl[k][i+1];
                dl[k][lat(k)-1] = cur;
                if (was_read) begin
                    rd_head[k]++;
                    rd_cnt[k]--;
                end
                if (fin[k]) begin
                    fin[k] = 1'b0;
                end else if (!active[k]) begin
                    if (start_i) begin
                        nblk[k]  = (int'(nb_i) > 8) ? 8 : int'(nb_i);
                        mbase[k] = base_i;
                        blk[k]   = 0;
                        if (nblk[k] == 0) fin[k] = 1'b1;
                        else begin
                            active[k] = 1'b1;
                            load_block(k);
                        end
                    end
                end else if (!was_read && ack_i && empty) begin
                    if (blk[k] == nblk[k] - 1) begin
                        active[k] = 1'b0;
                        fin[k]    = 1'b1;
                    end else begin
                        blk[k]++;
                        load_block(k);
                    end
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, actual, expected, $time);
        end
    endtask

    int         rdcnt [2];
    int         lbcnt [2];
    int         dncnt [2];
    logic [6:0] first_a [2];
    logic [6:0] last_a [2];

    always @(negedge clock) begin
        if (mon_en) begin
            chk("cycle_lat1", 32'(act[0]), 32'(exp_obs(0)));
            chk("cycle_lat3", 32'(act[1]), 32'(exp_obs(1)));
            for (int k = 0; k < 2; k++) begin
                if (act[k].rd) begin
                    if (rdcnt[k] == 0) first_a[k] = act[k].a;
                    last_a[k] = act[k].a;
                    rdcnt[k]++;
                end
                if (act[k].v && act[k].lb) lbcnt[k]++;
                if (act[k].done) dncnt[k]++;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_counts();
        for (int k = 0; k < 2; k++) begin
            rdcnt[k] = 0; lbcnt[k] = 0; dncnt[k] = 0;
            first_a[k] = '0; last_a[k] = '0;
        end
    endtask

    task automatic start_msg(input int nb, input int base);
        start_i = 1'b1;
        nb_i    = 4'(nb);
        base_i  = 7'(base);
        tick();
        start_i = 1'b0;
    endtask

    task automatic run_until_idle(input string nm, input bit rand_ack, input bit rand_abort);
        bit ok = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!act[0].busy && !act[1].busy) begin
                ok = 1'b1;
                break;
            end
            ack_i   = rand_ack ? ($urandom % 3 == 0) : 1'b1;
            abort_i = rand_abort && ($urandom % 300 == 0);
            start_i = act[0].busy && act[1].busy && ($urandom % 10 == 0);
            nb_i    = 4'($urandom);
            base_i  = 7'($urandom);
            tick();
        end
        start_i = 1'b0;
        ack_i   = 1'b0;
        abort_i = 1'b0;
        chk({nm, "_reaches_idle"}, 32'(ok), 32'd1);
    endtask

    task automatic wait_read_addr(input int k, input int addr, input string nm);
        bit ok = 1'b0;
        for (int c = 0; c < 500; c++) begin
            if (act[k].rd && act[k].a == 7'(addr)) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk({nm, "_addr_seen"}, 32'(ok), 32'd1);
    endtask

    scn_t tbl [6];

    initial begin
        tbl[0] = '{nb: 2,  base: 0,   exp_reads: 32,  exp_first: 0,   exp_last: 31,  exp_lb: 16, exp_done: 1};
        tbl[1] = '{nb: 0,  base: 5,   exp_reads: 0,   exp_first: 0,   exp_last: 0,   exp_lb: 0,  exp_done: 1};
        tbl[2] = '{nb: 12, base: 0,   exp_reads: 128, exp_first: 0,   exp_last: 127, exp_lb: 16, exp_done: 1};
        tbl[3] = '{nb: 1,  base: 125, exp_reads: 16,  exp_first: 125, exp_last: 12,  exp_lb: 16, exp_done: 1};
        tbl[4] = '{nb: 3,  base: 40,  exp_reads: 48,  exp_first: 40,  exp_last: 87,  exp_lb: 16, exp_done: 1};
        tbl[5] = '{nb: 15, base: 100, exp_reads: 128, exp_first: 100, exp_last: 99,  exp_lb: 16, exp_done: 1};

        clear_counts();
        @(posedge clock);
        #1 mon_en = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        chk("reset_state_lat1", 32'(act[0]), 32'd0);
        chk("reset_state_lat3", 32'(act[1]), 32'd0);

        // zero-block message: FINISH for exactly one cycle
        start_msg(0, 9);
        chk("nb0_done", 32'(act[0].done), 32'd1);
        chk("nb0_busy", 32'(act[0].busy), 32'd1);
        chk("nb0_no_read", 32'(act[1].rd), 32'd0);
        tick();
        chk("nb0_done_cleared", 32'(act[0].done), 32'd0);
        chk("nb0_busy_cleared", 32'(act[1].busy), 32'd0);

        foreach (tbl[i]) begin
            clear_counts();
            start_msg(tbl[i].nb, tbl[i].base);
            run_until_idle("table", 1'b1, 1'b0);
            for (int k = 0; k < 2; k++) begin
                chk("table_reads", 32'(rdcnt[k]), 32'(tbl[i].exp_reads));
                chk("table_last_block_words", 32'(lbcnt[k]), 32'(tbl[i].exp_lb));
                chk("table_done", 32'(dncnt[k]), 32'(tbl[i].exp_done));
                chk("table_first_addr", 32'(first_a[k]), 32'(tbl[i].exp_first));
                chk("table_last_addr", 32'(last_a[k]), 32'(tbl[i].exp_last));
            end
        end

        // reset in the middle of block 1, then a fresh message starts at base
        start_msg(3, 8);
        ack_i = 1'b1;
        wait_read_addr(0, 29, "reset_mid");
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ack_i = 1'b0;
        chk("reset_mid_outputs_lat1", 32'(act[0]), 32'd0);
        chk("reset_mid_outputs_lat3", 32'(act[1]), 32'd0);
        tick();
        chk("reset_mid_no_done", 32'({act[0].done, act[1].done}), 32'd0);
        start_msg(1, 0);
        chk("restart_read", 32'(act[0].rd), 32'd1);
        chk("restart_addr", 32'(act[0].a), 32'd0);
        run_until_idle("restart", 1'b0, 1'b0);

        // early acks ignored until the latency pipe drains
        start_msg(2, 0);
        ack_i = 1'b0;
        wait_read_addr(1, 15, "early_ack");
        tick();
        ack_i = 1'b1;
        tick();
        chk("early_ack_lat1_ignored", 32'(act[0].rd), 32'd0);
        chk("early_ack_lat3_ignored", 32'(act[1].rd), 32'd0);
        tick();
        ack_i = 1'b0;
        chk("drained_ack_lat1_next_read", 32'({act[0].rd, act[0].a}), 32'({1'b1, 7'd16}));
        chk("waiting_lat3_no_read", 32'(act[1].rd), 32'd0);
        chk("lat3_last_word_out", 32'({act[1].v, act[1].w, act[1].l}), 32'({1'b1, 4'd15, 1'b1}));
        tick();
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        chk("drained_ack_lat3_next_read", 32'({act[1].rd, act[1].a}), 32'({1'b1, 7'd16}));
        run_until_idle("early_ack", 1'b0, 1'b0);

        // abort while waiting for ack, with ack in the same cycle
        clear_counts();
        start_msg(2, 0);
        ack_i = 1'b0;
        wait_read_addr(1, 15, "abort_wait");
        repeat (4) tick();
        abort_i = 1'b1;
        ack_i   = 1'b1;
        tick();
        abort_i = 1'b0;
        ack_i   = 1'b0;
        chk("abort_idle_lat1", 32'({act[0].busy, act[0].rd}), 32'd0);
        chk("abort_idle_lat3", 32'({act[1].busy, act[1].rd}), 32'd0);
        repeat (4) tick();
        chk("abort_reads", 32'(rdcnt[0] + rdcnt[1]), 32'd32);
        chk("abort_no_done", 32'(dncnt[0] + dncnt[1]), 32'd0);

        // randomized messages with random acks, stray starts and rare aborts
        for (int r = 0; r < 25; r++) begin
            start_msg(int'($urandom_range(0, 15)), int'($urandom_range(0, 127)));
            run_until_idle("random", 1'b1, 1'b1);
            repeat ($urandom_range(0, 3)) tick();
        end

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
